// File: rtl/vga_timing_pkg.sv
// Shared constants for the VGA raster timing generator: 640x480@60 defaults
// and sync polarity encodings.
package vga_timing_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam bit SYNC_ACT_LOW  = 1'b0;
  localparam bit SYNC_ACT_HIGH = 1'b1;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster output bundle of the VGA timing generator plus its pixel advance strobe.
interface vga_timing_gen_if #(
  parameter int CNT_W   = 10,
  parameter int FRAME_W = 8
);
  logic               en;
  logic [CNT_W-1:0]   hc;
  logic [CNT_W-1:0]   vc;
  logic               hsync;
  logic               vsync;
  logic               vidon;
  logic               line_start;
  logic               frame_start;
  logic [FRAME_W-1:0] frame_cnt;

  modport master (
    input  en,
    output hc, vc, hsync, vsync, vidon, line_start, frame_start, frame_cnt
  );

  modport slave (
    output en,
    input  hc, vc, hsync, vsync, vidon, line_start, frame_start, frame_cnt
  );
endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter (ACTIVE, FP, SYNC, BP order) with wrap flag,
// registered sync decode and the next-count active decode.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = H_ACTIVE,
  parameter int FP     = H_FP,
  parameter int SYNC   = H_SYNC,
  parameter int BP     = H_BP,
  parameter bit POL    = SYNC_ACT_LOW,
  parameter int W      = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         adv,
  output logic [W-1:0] cnt,
  output logic         wrap,
  output logic         sync,
  output logic         act_nxt
);

  localparam int          TOTAL   = ACTIVE + FP + SYNC + BP;
  localparam logic [W-1:0] LAST    = W'(TOTAL - 1);
  localparam logic [W-1:0] SYNC_LO = W'(ACTIVE + FP);
  localparam logic [W-1:0] SYNC_HI = W'(ACTIVE + FP + SYNC);
  localparam logic [W-1:0] ACT_END = W'(ACTIVE);

  logic [W-1:0] cnt_d, cnt_q;
  logic         sync_d, sync_q;

  assign wrap = (cnt_q == LAST);

  // Decodes look at the next count so they land on the same edge as the count.
  always_comb begin
    cnt_d = cnt_q;
    if (adv) begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
    end
    sync_d  = ((cnt_d >= SYNC_LO) && (cnt_d < SYNC_HI)) ? POL : ~POL;
    act_nxt = (cnt_d < ACT_END);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= LAST;
      sync_q <= ~POL;
    end else begin
      cnt_q  <= cnt_d;
      sync_q <= sync_d;
    end
  end

  assign cnt  = cnt_q;
  assign sync = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: horizontal/vertical axis counters,
// registered video-enable, line/frame strobes and a completed-frame counter.
module vga_timing_gen #(
  parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int H_FP     = vga_timing_pkg::H_FP,
  parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int H_BP     = vga_timing_pkg::H_BP,
  parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int V_FP     = vga_timing_pkg::V_FP,
  parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int V_BP     = vga_timing_pkg::V_BP,
  parameter bit HS_POL   = vga_timing_pkg::SYNC_ACT_LOW,
  parameter bit VS_POL   = vga_timing_pkg::SYNC_ACT_LOW,
  parameter int CNT_W    = 10,
  parameter int FRAME_W  = 8
) (
  input  logic              clk25,
  input  logic              rst_n,
  vga_timing_gen_if.master  vif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1) begin : g_bad_h
    $error("vga_timing_gen: horizontal timing has a zero-width region");
  end
  if (V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_v
    $error("vga_timing_gen: vertical timing has a zero-width region");
  end
  if (CNT_W < 1 || CNT_W > 30 || (2**CNT_W) < H_TOTAL || (2**CNT_W) < V_TOTAL) begin : g_bad_w
    $error("vga_timing_gen: CNT_W too small for H_TOTAL/V_TOTAL");
  end
  if (FRAME_W < 1) begin : g_bad_fw
    $error("vga_timing_gen: FRAME_W must be at least 1");
  end

  logic [CNT_W-1:0]   hc, vc;
  logic               h_wrap, v_wrap, h_act_nxt, v_act_nxt, v_adv;
  logic               vidon_d, vidon_q;
  logic               line_start_d, line_start_q;
  logic               frame_start_d, frame_start_q;
  logic               first_d, first_q;
  logic [FRAME_W-1:0] frame_cnt_d, frame_cnt_q;

  assign v_adv = vif.en & h_wrap;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HS_POL), .W(CNT_W)
  ) u_h_cnt (
    .clk(clk25), .rst_n(rst_n), .adv(vif.en),
    .cnt(hc), .wrap(h_wrap), .sync(vif.hsync), .act_nxt(h_act_nxt)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VS_POL), .W(CNT_W)
  ) u_v_cnt (
    .clk(clk25), .rst_n(rst_n), .adv(v_adv),
    .cnt(vc), .wrap(v_wrap), .sync(vif.vsync), .act_nxt(v_act_nxt)
  );

  // Reset parks both counters on their last value, so the first en wraps both;
  // first_q keeps that wrap from counting as a completed frame.
  always_comb begin
    vidon_d       = h_act_nxt & v_act_nxt;
    line_start_d  = vif.en & h_wrap;
    frame_start_d = vif.en & h_wrap & v_wrap;
    first_d       = first_q & ~vif.en;
    frame_cnt_d   = frame_cnt_q;
    if (frame_start_d && !first_q) begin
      frame_cnt_d = frame_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      vidon_q       <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      first_q       <= 1'b1;
      frame_cnt_q   <= '0;
    end else begin
      vidon_q       <= vidon_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      first_q       <= first_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign vif.hc          = hc;
  assign vif.vc          = vc;
  assign vif.vidon       = vidon_q;
  assign vif.line_start  = line_start_q;
  assign vif.frame_start = frame_start_q;
  assign vif.frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480, a small 15x8 raster, and the same
// small raster with inverted sync polarity, all on one shared en/reset stream.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [15:0] hc;
    logic [15:0] vc;
    logic        hs;
    logic        vs;
    logic        vid;
    logic        ls;
    logic        fs;
    logic [7:0]  fc;
  } smp_t;

  logic clk25 = 1'b0;
  logic rst_n;
  logic en;
  int   total = 0;
  int   bad   = 0;

  always #20 clk25 = ~clk25;

  vga_timing_gen_if #(.CNT_W(10), .FRAME_W(8)) if_a ();
  vga_timing_gen_if #(.CNT_W(4),  .FRAME_W(2)) if_b ();
  vga_timing_gen_if #(.CNT_W(4),  .FRAME_W(2)) if_c ();

  assign if_a.en = en;
  assign if_b.en = en;
  assign if_c.en = en;

  vga_timing_gen u_a (.clk25(clk25), .rst_n(rst_n), .vif(if_a.master));

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .CNT_W(4), .FRAME_W(2)
  ) u_b (.clk25(clk25), .rst_n(rst_n), .vif(if_b.master));

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(4), .FRAME_W(2)
  ) u_c (.clk25(clk25), .rst_n(rst_n), .vif(if_c.master));

  int ha[3]  = '{640, 8, 8};
  int hf[3]  = '{16, 2, 2};
  int hsw[3] = '{96, 3, 3};
  int hb[3]  = '{48, 2, 2};
  int va[3]  = '{480, 4, 4};
  int vf[3]  = '{10, 1, 1};
  int vsw[3] = '{2, 2, 2};
  int vb[3]  = '{33, 1, 1};
  int pol[3] = '{0, 0, 1};
  int fw[3]  = '{8, 2, 2};
  string names[3] = '{"cyc_a", "cyc_b", "cyc_c"};

  int m_hc[3], m_vc[3], m_fc[3];
  bit m_first[3], m_ls[3], m_fs[3];
  smp_t sbq[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic int htot(int c);
    return ha[c] + hf[c] + hsw[c] + hb[c];
  endfunction

  function automatic int vtot(int c);
    return va[c] + vf[c] + vsw[c] + vb[c];
  endfunction

  function automatic void model_reset(int c);
    m_hc[c] = htot(c) - 1;
    m_vc[c] = vtot(c) - 1;
    m_fc[c] = 0;
    m_first[c] = 1'b1;
    m_ls[c] = 1'b0;
    m_fs[c] = 1'b0;
  endfunction

  function automatic void model_step(int c, logic e);
    if (!rst_n) begin
      model_reset(c);
      return;
    end
    m_ls[c] = 1'b0;
    m_fs[c] = 1'b0;
    if (e) begin
      if (m_hc[c] == htot(c) - 1) begin
        m_hc[c] = 0;
        m_vc[c] = (m_vc[c] == vtot(c) - 1) ? 0 : m_vc[c] + 1;
      end else begin
        m_hc[c] = m_hc[c] + 1;
      end
      m_ls[c] = (m_hc[c] == 0);
      m_fs[c] = m_ls[c] && (m_vc[c] == 0);
      if (m_fs[c] && !m_first[c]) m_fc[c] = (m_fc[c] + 1) % (1 << fw[c]);
      m_first[c] = 1'b0;
    end
  endfunction

  function automatic smp_t model_out(int c);
    smp_t s;
    logic p;
    p = (pol[c] != 0);
    s = '0;
    s.hc  = 16'(m_hc[c]);
    s.vc  = 16'(m_vc[c]);
    s.hs  = (m_hc[c] >= ha[c] + hf[c] && m_hc[c] < ha[c] + hf[c] + hsw[c]) ? p : ~p;
    s.vs  = (m_vc[c] >= va[c] + vf[c] && m_vc[c] < va[c] + vf[c] + vsw[c]) ? p : ~p;
    s.vid = (m_hc[c] < ha[c]) && (m_vc[c] < va[c]);
    s.ls  = m_ls[c];
    s.fs  = m_fs[c];
    s.fc  = 8'(m_fc[c]);
    return s;
  endfunction

  function automatic smp_t obs(int c);
    smp_t s;
    s = '0;
    case (c)
      0: begin
        s.hc = 16'(if_a.hc); s.vc = 16'(if_a.vc); s.hs = if_a.hsync; s.vs = if_a.vsync;
        s.vid = if_a.vidon; s.ls = if_a.line_start; s.fs = if_a.frame_start;
        s.fc = 8'(if_a.frame_cnt);
      end
      1: begin
        s.hc = 16'(if_b.hc); s.vc = 16'(if_b.vc); s.hs = if_b.hsync; s.vs = if_b.vsync;
        s.vid = if_b.vidon; s.ls = if_b.line_start; s.fs = if_b.frame_start;
        s.fc = 8'(if_b.frame_cnt);
      end
      default: begin
        s.hc = 16'(if_c.hc); s.vc = 16'(if_c.vc); s.hs = if_c.hsync; s.vs = if_c.vsync;
        s.vid = if_c.vidon; s.ls = if_c.line_start; s.fs = if_c.frame_start;
        s.fc = 8'(if_c.frame_cnt);
      end
    endcase
    return s;
  endfunction

  function automatic int q_at(input int q[$], input int k);
    return (q.size() > k) ? q[k] : -1;
  endfunction

  task automatic check_now();
    smp_t e;
    for (int c = 0; c < 3; c++) sbq.push_back(model_out(c));
    for (int c = 0; c < 3; c++) begin
      e = sbq.pop_front();
      chk(names[c], 64'(obs(c)), 64'(e));
    end
  endtask

  task automatic tick(input logic en_v);
    en = en_v;
    @(posedge clk25);
    for (int c = 0; c < 3; c++) model_step(c, en_v);
    #1;
    check_now();
  endtask

  int a_hs_lo, a_vid, b_vs_lo, c_vs_hi, dbl, b_moves, guard;
  int a_ls_at[$], b_fs_at[$], b_fc_at_fs[$], t_fs_at[$];
  logic prev_a_ls, prev_b_ls, prev_b_fs;
  logic [3:0] prev_b_hc;
  smp_t fe;

  initial begin
    #1ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    a_hs_lo = 0; a_vid = 0; b_vs_lo = 0; c_vs_hi = 0; dbl = 0; b_moves = 0; guard = 0;
    en = 1'b0;
    rst_n = 1'b1;
    #5 rst_n = 1'b0;
    for (int c = 0; c < 3; c++) model_reset(c);
    #1 check_now();
    tick(1'b0);
    tick(1'b1);
    @(negedge clk25) rst_n = 1'b1;

    // free-running en=1
    for (int i = 0; i < 1700; i++) begin
      tick(1'b1);
      if (i == 0) begin
        fe = '0; fe.hs = 1'b1; fe.vs = 1'b1; fe.vid = 1'b1; fe.ls = 1'b1; fe.fs = 1'b1;
        chk("first_edge_a", 64'(obs(0)), 64'(fe));
        fe.hs = 1'b0; fe.vs = 1'b0;
        chk("first_edge_c", 64'(obs(2)), 64'(fe));
      end
      if (i < 800) begin
        if (!if_a.hsync) a_hs_lo++;
        if (if_a.vidon) a_vid++;
      end
      if (if_a.line_start) a_ls_at.push_back(i);
      if (i < 120) begin
        if (!if_b.vsync) b_vs_lo++;
        if (if_c.vsync) c_vs_hi++;
      end
      if (if_b.frame_start) begin
        b_fs_at.push_back(i);
        b_fc_at_fs.push_back(int'(if_b.frame_cnt));
      end
    end
    chk("a_hsync_low_clks", 64'(a_hs_lo), 64'd96);
    chk("a_vidon_clks", 64'(a_vid), 64'd640);
    chk("a_line_period", 64'(q_at(a_ls_at, 1) - q_at(a_ls_at, 0)), 64'd800);
    chk("b_vsync_low_clks", 64'(b_vs_lo), 64'd30);
    chk("c_vsync_high_clks", 64'(c_vs_hi), 64'd30);
    chk("b_frame_period", 64'(q_at(b_fs_at, 1) - q_at(b_fs_at, 0)), 64'd120);
    chk("b_fc_2nd_fs", 64'(q_at(b_fc_at_fs, 1)), 64'd1);
    chk("b_fc_4th_fs", 64'(q_at(b_fc_at_fs, 3)), 64'd3);
    chk("b_fc_5th_fs", 64'(q_at(b_fc_at_fs, 4)), 64'd0);

    // en toggling every clk
    prev_a_ls = if_a.line_start;
    prev_b_ls = if_b.line_start;
    prev_b_fs = if_b.frame_start;
    prev_b_hc = if_b.hc;
    for (int i = 0; i < 480; i++) begin
      tick((i % 2) == 0);
      if (if_a.line_start && prev_a_ls) dbl++;
      if (if_b.line_start && prev_b_ls) dbl++;
      if (if_b.frame_start && prev_b_fs) dbl++;
      if (if_b.hc != prev_b_hc) b_moves++;
      if (if_b.frame_start) t_fs_at.push_back(i);
      prev_a_ls = if_a.line_start;
      prev_b_ls = if_b.line_start;
      prev_b_fs = if_b.frame_start;
      prev_b_hc = if_b.hc;
    end
    chk("tog_pulse_width", 64'(dbl), 64'd0);
    chk("tog_b_hc_steps", 64'(b_moves), 64'd240);
    chk("tog_b_frame_period", 64'(q_at(t_fs_at, 1) - q_at(t_fs_at, 0)), 64'd240);

    // reset mid-frame on the small raster
    while (!(m_hc[1] == 10 && m_vc[1] == 5) && guard < 300) begin
      tick(1'b1);
      guard++;
    end
    chk("seek_b_in_budget", 64'(guard < 300), 64'd1);
    #5 rst_n = 1'b0;
    for (int c = 0; c < 3; c++) model_reset(c);
    #1 check_now();
    chk("rst_b_hc", 64'(if_b.hc), 64'd14);
    chk("rst_b_vc", 64'(if_b.vc), 64'd7);
    tick(1'b1);
    tick(1'b1);
    @(negedge clk25) rst_n = 1'b1;
    tick(1'b1);
    chk("post_rst_b_hc", 64'(if_b.hc), 64'd0);
    chk("post_rst_b_vc", 64'(if_b.vc), 64'd0);
    chk("post_rst_b_fs", 64'(if_b.frame_start), 64'd1);
    chk("post_rst_a_fc", 64'(if_a.frame_cnt), 64'd0);
    for (int i = 0; i < 20; i++) tick(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
